// File: rtl/serializador_pkg.sv
// rtl/serializador_pkg.sv - shared types and default sizes for the buffer serializer
//
// Purpose : FSM state encoding and default word/chunk widths used by
//           serializador_buffer and anything that instantiates it.
// Contents: estado_t (IDLE, SEND), WIDTH_DEF, OUT_WIDTH_DEF.

package serializador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } estado_t;

    localparam int WIDTH_DEF     = 64;
    localparam int OUT_WIDTH_DEF = 8;

endpackage : serializador_pkg

// File: rtl/serializador_buffer.sv
// rtl/serializador_buffer.sv - pops words from a FWFT circular buffer and streams them out in narrow chunks
//
// Purpose : Consumer of the BufferCircular FIFO. Each popped WIDTH-bit word is
//           sent as WIDTH/OUT_WIDTH chunks, least significant chunk first, on a
//           valid/ready stream. A new word is reloaded on the same edge the last
//           chunk of the previous word is accepted, so a sustained stream has no
//           bubbles between words.
// Ports   :
//   clk_i       in   1          clock, rising edge
//   rstn_i      in   1          asynchronous reset, active low
//   vacia_i     in   1          buffer empty flag
//   dato_i      in   WIDTH      buffer head word (valid whenever vacia_i=0)
//   delecion_o  out  1          pop request, takes effect on the same edge
//   valid_o     out  1          data_o holds a valid chunk
//   ready_i     in   1          sink accepts the chunk this cycle
//   data_o      out  OUT_WIDTH  current output chunk
//   ultimo_o    out  1          data_o is the last chunk of its word
//   ocupado_o   out  1          a word is held (state SEND)

module serializador_buffer
    import serializador_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 vacia_i,
    input  logic [WIDTH-1:0]     dato_i,
    output logic                 delecion_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 ultimo_o,
    output logic                 ocupado_o
);

    localparam int NUM_CHUNKS = WIDTH / OUT_WIDTH;
    // Keep the counter at least one bit wide so a one-chunk configuration still elaborates.
    localparam int CNT_SIZE   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(NUM_CHUNKS - 1);

    if ((WIDTH % OUT_WIDTH) != 0) begin : g_width_check
        $error("serializador_buffer: WIDTH must be a multiple of OUT_WIDTH");
    end

    estado_t             estado;
    estado_t             estado_sig;
    logic [WIDTH-1:0]    shreg;
    logic [CNT_SIZE-1:0] cnt;

    logic handshake;   // chunk accepted on the coming edge
    logic es_ultimo;   // chunk on data_o is the last of its word
    logic carga;       // load dato_i into shreg (always coincides with a pop)
    logic avanza;      // shift to the next chunk of the same word

    always_comb begin
        estado_sig = estado;
        valid_o    = 1'b0;
        data_o     = '0;
        ultimo_o   = 1'b0;
        ocupado_o  = 1'b0;
        delecion_o = 1'b0;
        handshake  = 1'b0;
        es_ultimo  = 1'b0;
        carga      = 1'b0;
        avanza     = 1'b0;

        case (estado)
            IDLE: begin
                // Head word is valid as soon as vacia_i falls; take it immediately.
                delecion_o = !vacia_i;
                carga      = !vacia_i;
                if (!vacia_i) begin
                    estado_sig = SEND;
                end
            end

            SEND: begin
                // valid_o and data_o come only from registered state, never from ready_i.
                valid_o   = 1'b1;
                ocupado_o = 1'b1;
                data_o    = shreg[OUT_WIDTH-1:0];
                es_ultimo = (cnt == LAST_CNT);
                ultimo_o  = es_ultimo;
                handshake = ready_i;
                avanza    = handshake && !es_ultimo;

                if (handshake && es_ultimo) begin
                    if (!vacia_i) begin
                        // Back-to-back reload: pop the next word in the same cycle.
                        delecion_o = 1'b1;
                        carga      = 1'b1;
                    end else begin
                        estado_sig = IDLE;
                    end
                end
            end

            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            estado <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
        end else begin
            estado <= estado_sig;
            if (carga) begin
                shreg <= dato_i;
                cnt   <= '0;
            end else if (avanza) begin
                shreg <= shreg >> OUT_WIDTH;
                cnt   <= cnt + CNT_SIZE'(1);
            end
        end
    end

endmodule : serializador_buffer
